// File: rtl/dense_layer_sched.sv
// Fully-connected layer sequencer: streams 25-word input/weight chunks into the shared
// dot-product unit, chains partial sums through the bias field, and writes one word per neuron.
module dense_layer_sched #(
    parameter int WIDTH       = 16,
    parameter int IN_LEN      = 50,
    parameter int OUT_NEURONS = 10,
    parameter int IN_BASE     = 0,
    parameter int OUT_BASE    = 0,
    parameter int WADDR_W     = 8,
    parameter int RELU_EN     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                layer_en_i,
    output logic                layer_done_o,
    output logic                output_buf_en_o,
    output logic [32*5-1:0]     data_from_buf_addr_o,
    input  logic [WIDTH*5-1:0]  data_from_buf_i,
    output logic [WADDR_W-1:0]  wgt_addr_o,
    input  logic [WIDTH*25-1:0] wgt_data_i,
    output logic [WADDR_W-1:0]  bias_addr_o,
    input  logic [WIDTH-1:0]    bias_data_i,
    output logic                calc_vld_o,
    output logic [WIDTH*51-1:0] data_to_calc_o,
    input  logic                calc_vld_i,
    input  logic [WIDTH-1:0]    data_from_calc_i,
    output logic [31:0]         data_to_buf_addr_o,
    output logic [WIDTH-1:0]    data_to_buf_o,
    output logic                wr_en_o
);

    localparam int CHUNKS = IN_LEN / 25;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int NW     = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        beat_q, beat_d;
    logic [CW-1:0]     chunk_q, chunk_d;
    logic [NW-1:0]     neuron_q, neuron_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              en_q;
    logic [WIDTH-1:0]  buf_q [25];
    logic [WIDTH*51-1:0] calc_word_s;

    function automatic logic [WIDTH-1:0] relu_f(input logic [WIDTH-1:0] v);
        if ((RELU_EN != 32'sd0) && v[WIDTH-1]) begin
            relu_f = '0;
        end else begin
            relu_f = v;
        end
    endfunction

    // Next-state logic for the layer sequencer and its counters.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        chunk_d  = chunk_q;
        neuron_d = neuron_q;
        acc_d    = acc_q;
        case (state_q)
            S_IDLE: begin
                if (layer_en_i && !en_q) begin
                    neuron_d = '0;
                    chunk_d  = '0;
                    beat_d   = 3'd0;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_FETCH: begin
                if (beat_q == 3'd5) begin
                    beat_d  = 3'd0;
                    state_d = S_ISSUE;
                end else begin
                    beat_d  = beat_q + 3'd1;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (calc_vld_i) begin
                    acc_d = data_from_calc_i;
                    if (chunk_q == CW'(CHUNKS - 1)) begin
                        state_d = S_WRITE;
                    end else begin
                        chunk_d = chunk_q + CW'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WRITE: begin
                if (neuron_q == NW'(OUT_NEURONS - 1)) begin
                    state_d  = S_DONE;
                end else begin
                    neuron_d = neuron_q + NW'(1);
                    chunk_d  = '0;
                    state_d  = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Issue word; the last five input words are still on the read bus when ISSUE is entered.
    always_comb begin
        calc_word_s = '0;
        for (int w = 0; w < 20; w++) begin
            calc_word_s[(26 + w) * WIDTH +: WIDTH] = buf_q[w];
        end
        for (int w = 0; w < 5; w++) begin
            calc_word_s[(46 + w) * WIDTH +: WIDTH] = data_from_buf_i[w * WIDTH +: WIDTH];
        end
        calc_word_s[WIDTH +: 25 * WIDTH] = wgt_data_i;
        if (chunk_q == '0) begin
            calc_word_s[WIDTH-1:0] = bias_data_i;
        end else begin
            calc_word_s[WIDTH-1:0] = acc_q;
        end
    end

    // State, counters, accumulator, start-edge history and chunk buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            beat_q   <= 3'd0;
            chunk_q  <= '0;
            neuron_q <= '0;
            acc_q    <= '0;
            en_q     <= 1'b0;
            for (int w = 0; w < 25; w++) begin
                buf_q[w] <= '0;
            end
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            chunk_q  <= chunk_d;
            neuron_q <= neuron_d;
            acc_q    <= acc_d;
            en_q     <= layer_en_i;
            for (int w = 0; w < 25; w++) begin
                if (state_q == S_FETCH && beat_q == 3'(w / 5 + 1)) begin
                    buf_q[w] <= data_from_buf_i[(w % 5) * WIDTH +: WIDTH];
                end
            end
        end
    end

    // Registered outputs, loaded from next-state values so they align with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_done_o         <= 1'b0;
            output_buf_en_o      <= 1'b0;
            data_from_buf_addr_o <= '0;
            wgt_addr_o           <= '0;
            bias_addr_o          <= '0;
            calc_vld_o           <= 1'b0;
            data_to_calc_o       <= '0;
            data_to_buf_addr_o   <= 32'd0;
            data_to_buf_o        <= '0;
            wr_en_o              <= 1'b0;
        end else begin
            output_buf_en_o <= (state_d != S_IDLE);
            calc_vld_o      <= (state_d == S_ISSUE);
            wr_en_o         <= (state_d == S_WRITE);
            layer_done_o    <= (state_d == S_DONE);
            if (state_d == S_FETCH && beat_d < 3'd5) begin
                for (int l = 0; l < 5; l++) begin
                    data_from_buf_addr_o[32 * l +: 32] <= 32'(IN_BASE) + 32'(chunk_d) * 32'd25
                                                        + 32'(beat_d) * 32'd5 + 32'(l);
                end
            end
            if (state_d == S_FETCH && beat_d == 3'd0) begin
                wgt_addr_o  <= WADDR_W'(32'(neuron_d) * 32'(CHUNKS) + 32'(chunk_d));
                bias_addr_o <= WADDR_W'(neuron_d);
            end
            if (state_d == S_ISSUE) begin
                data_to_calc_o <= calc_word_s;
            end
            if (state_d == S_WRITE) begin
                data_to_buf_addr_o <= 32'(OUT_BASE) + 32'(neuron_d);
                data_to_buf_o      <= relu_f(acc_d);
            end
        end
    end

endmodule

// File: tb/tb_dense_layer_sched.sv
// Scoreboard bench for dense_layer_sched: two instances (ReLU on/off) share memory and calc models.
module tb_dense_layer_sched;

    localparam int IN_LEN_P  = 50;
    localparam int OUT_N_P   = 3;
    localparam int IN_BASE_P = 8;
    localparam int OUT_BASE_P = 40;

    logic clk, rst_n, layer_en;
    logic layer_done_o, output_buf_en_o, calc_vld_o, wr_en_o, calc_vld_i;
    logic [159:0] data_from_buf_addr_o;
    logic [79:0]  data_from_buf_i;
    logic [7:0]   wgt_addr_o, bias_addr_o;
    logic [399:0] wgt_data_i;
    logic [15:0]  bias_data_i, data_from_calc_i, data_to_buf_o;
    logic [815:0] data_to_calc_o;
    logic [31:0]  data_to_buf_addr_o;

    logic n_done, n_obe, n_cvld, n_wr;
    logic [159:0] n_baddr;
    logic [7:0]   n_waddr, n_baddr2;
    logic [815:0] n_calc;
    logic [31:0]  n_oaddr;
    logic [15:0]  n_odata;

    logic [15:0]  in_mem [0:63];
    logic [399:0] wgt_rom [0:7];
    logic [15:0]  bias_rom [0:3];

    logic [815:0] q_issue [$];
    logic [31:0]  q_waddr [$];
    logic [15:0]  q_wdata [$];
    logic [15:0]  q_wraw [$];

    int errors = 0;
    int checks = 0;

    dense_layer_sched #(.WIDTH(16), .IN_LEN(IN_LEN_P), .OUT_NEURONS(OUT_N_P), .IN_BASE(IN_BASE_P),
                        .OUT_BASE(OUT_BASE_P), .WADDR_W(8), .RELU_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .layer_en_i(layer_en), .layer_done_o(layer_done_o),
        .output_buf_en_o(output_buf_en_o), .data_from_buf_addr_o(data_from_buf_addr_o),
        .data_from_buf_i(data_from_buf_i), .wgt_addr_o(wgt_addr_o), .wgt_data_i(wgt_data_i),
        .bias_addr_o(bias_addr_o), .bias_data_i(bias_data_i), .calc_vld_o(calc_vld_o),
        .data_to_calc_o(data_to_calc_o), .calc_vld_i(calc_vld_i), .data_from_calc_i(data_from_calc_i),
        .data_to_buf_addr_o(data_to_buf_addr_o), .data_to_buf_o(data_to_buf_o), .wr_en_o(wr_en_o)
    );

    dense_layer_sched #(.WIDTH(16), .IN_LEN(IN_LEN_P), .OUT_NEURONS(OUT_N_P), .IN_BASE(IN_BASE_P),
                        .OUT_BASE(OUT_BASE_P), .WADDR_W(8), .RELU_EN(0)) u_dut_norelu (
        .clk(clk), .rst_n(rst_n), .layer_en_i(layer_en), .layer_done_o(n_done),
        .output_buf_en_o(n_obe), .data_from_buf_addr_o(n_baddr),
        .data_from_buf_i(data_from_buf_i), .wgt_addr_o(n_waddr), .wgt_data_i(wgt_data_i),
        .bias_addr_o(n_baddr2), .bias_data_i(bias_data_i), .calc_vld_o(n_cvld),
        .data_to_calc_o(n_calc), .calc_vld_i(calc_vld_i), .data_from_calc_i(data_from_calc_i),
        .data_to_buf_addr_o(n_oaddr), .data_to_buf_o(n_odata), .wr_en_o(n_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models with one-cycle read latency.
    always @(posedge clk) begin
        for (int l = 0; l < 5; l++) begin
            data_from_buf_i[l*16 +: 16] <= in_mem[data_from_buf_addr_o[l*32 +: 6]];
        end
        wgt_data_i  <= wgt_rom[wgt_addr_o[2:0]];
        bias_data_i <= bias_rom[bias_addr_o[1:0]];
    end

    task automatic init_mem();
        for (int a = 0; a < 64; a++) in_mem[a] = 16'(a - IN_BASE_P + 1);
        for (int n = 0; n < 8; n++) wgt_rom[n] = '0;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 25; k++) begin
                wgt_rom[c][k*16 +: 16]     = 16'h0001;
                wgt_rom[2 + c][k*16 +: 16] = 16'hFFFF;
                wgt_rom[4 + c][k*16 +: 16] = 16'(((c * 25 + k) % 7) + 1);
            end
        end
        bias_rom[0] = 16'h0005;
        bias_rom[1] = 16'h0010;
        bias_rom[2] = 16'h0100;
        bias_rom[3] = 16'h0000;
    endtask

    task automatic build_expect();
        logic [815:0] e;
        logic [15:0] p;
        logic [15:0] a, b;
        for (int n = 0; n < OUT_N_P; n++) begin
            p = bias_rom[n];
            for (int c = 0; c < 2; c++) begin
                e = '0;
                e[15:0] = p;
                for (int k = 0; k < 25; k++) begin
                    a = in_mem[IN_BASE_P + c * 25 + k];
                    b = wgt_rom[n * 2 + c][k*16 +: 16];
                    e[(26 + k)*16 +: 16] = a;
                    e[(1 + k)*16 +: 16]  = b;
                    p = p + 16'(a * b);
                end
                q_issue.push_back(e);
            end
            q_waddr.push_back(32'(OUT_BASE_P + n));
            q_wdata.push_back(p[15] ? 16'h0000 : p);
            q_wraw.push_back(p);
        end
    endtask

    task automatic run_layer(input int lat_a, input int lat_b, input bit stray, input bit toggle_en,
                             input bit hold_en, input int abort_issue);
        int cyc = 0, cd = 0, scd = 0, issues = 0;
        bit done_seen = 1'b0, aborted = 1'b0;
        logic [15:0] res = 16'h0000;
        logic [815:0] e;
        logic [159:0] exp_addr;
        build_expect();
        @(negedge clk);
        layer_en = 1'b1;
        @(negedge clk);
        for (int l = 0; l < 5; l++) exp_addr[l*32 +: 32] = 32'(IN_BASE_P + l);
        checks++;
        if (data_from_buf_addr_o !== exp_addr) begin
            errors++; $display("FAIL start_addr act=%h exp=%h", data_from_buf_addr_o[31:0], exp_addr[31:0]);
        end
        checks++;
        if (bias_addr_o !== 8'd0) begin errors++; $display("FAIL start_bias_addr act=%0d exp=0", bias_addr_o); end
        checks++;
        if (wgt_addr_o !== 8'd0) begin errors++; $display("FAIL start_wgt_addr act=%0d exp=0", wgt_addr_o); end
        checks++;
        if (output_buf_en_o !== 1'b1) begin errors++; $display("FAIL start_buf_en act=%b exp=1", output_buf_en_o); end
        while (!done_seen && !aborted && cyc < 3000) begin
            calc_vld_i = 1'b0;
            if (!hold_en && cyc == 2) layer_en = 1'b0;
            if (toggle_en && cyc == 10) layer_en = 1'b1;
            if (toggle_en && cyc == 12) layer_en = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    calc_vld_i = 1'b1; data_from_calc_i = res; scd = stray ? 3 : 0;
                end
            end else if (scd > 0) begin
                scd--;
                if (scd == 0) begin calc_vld_i = 1'b1; data_from_calc_i = 16'hDEAD; end
            end
            if (calc_vld_o) begin
                checks++;
                if (q_issue.size() == 0) begin
                    errors++; $display("FAIL issue_extra act=strobe exp=none");
                end else begin
                    e = q_issue.pop_front();
                    if (data_to_calc_o !== e) begin
                        errors++;
                        $display("FAIL issue_fields idx=%0d act_bias=%h exp_bias=%h vecA_ok=%0b vecB_ok=%0b",
                                 issues, data_to_calc_o[15:0], e[15:0], data_to_calc_o[815:416] === e[815:416],
                                 data_to_calc_o[415:16] === e[415:16]);
                    end
                end
                res = data_to_calc_o[15:0];
                for (int k = 0; k < 25; k++)
                    res = res + 16'(data_to_calc_o[(26 + k)*16 +: 16] * data_to_calc_o[(1 + k)*16 +: 16]);
                cd = (issues % 2 == 0) ? lat_a : lat_b;
                issues++;
                if (abort_issue != 0 && issues == abort_issue) begin
                    @(negedge clk);
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    if ({layer_done_o, output_buf_en_o, data_from_buf_addr_o, wgt_addr_o, bias_addr_o, calc_vld_o,
                         data_to_calc_o, data_to_buf_addr_o, data_to_buf_o, wr_en_o} !== '0) begin
                        errors++;
                        $display("FAIL reset_mid_wait act_buf_en=%b act_bias_addr=%0d act_calc=%b exp=all zero",
                                 output_buf_en_o, bias_addr_o, calc_vld_o);
                    end
                    layer_en = 1'b0; calc_vld_i = 1'b0;
                    q_issue.delete(); q_waddr.delete(); q_wdata.delete(); q_wraw.delete();
                    repeat (3) @(negedge clk);
                    rst_n = 1'b1;
                    aborted = 1'b1;
                end
            end
            if (!aborted && wr_en_o) begin
                checks += 3;
                if (q_waddr.size() == 0) begin
                    errors++; $display("FAIL write_extra act_addr=%0d exp=none", data_to_buf_addr_o);
                end else begin
                    if (data_to_buf_addr_o !== q_waddr[0]) begin
                        errors++; $display("FAIL write_addr act=%0d exp=%0d", data_to_buf_addr_o, q_waddr[0]);
                    end
                    if (data_to_buf_o !== q_wdata[0]) begin
                        errors++; $display("FAIL write_data_relu act=%h exp=%h", data_to_buf_o, q_wdata[0]);
                    end
                    if (n_odata !== q_wraw[0]) begin
                        errors++; $display("FAIL write_data_norelu act=%h exp=%h", n_odata, q_wraw[0]);
                    end
                    void'(q_waddr.pop_front()); void'(q_wdata.pop_front()); void'(q_wraw.pop_front());
                end
            end
            if (!aborted && layer_done_o) done_seen = 1'b1;
            if (!aborted) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (aborted) return;
        checks++;
        if (!done_seen) begin errors++; $display("FAIL layer_timeout act=no_done exp=done cycles=%0d", cyc); end
        checks++;
        if (layer_done_o !== 1'b0) begin errors++; $display("FAIL done_pulse_width act=%b exp=0", layer_done_o); end
        checks++;
        if (output_buf_en_o !== 1'b0) begin errors++; $display("FAIL idle_buf_en act=%b exp=0", output_buf_en_o); end
        checks++;
        if (q_issue.size() != 0 || q_waddr.size() != 0) begin
            errors++; $display("FAIL queue_drain act_issue=%0d act_write=%0d exp=0", q_issue.size(), q_waddr.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; layer_en = 1'b0; calc_vld_i = 1'b0; data_from_calc_i = 16'h0000;
        init_mem();
        repeat (3) @(negedge clk);
        checks++;
        if ({layer_done_o, output_buf_en_o, data_from_buf_addr_o, wgt_addr_o, bias_addr_o, calc_vld_o,
             data_to_calc_o, data_to_buf_addr_o, data_to_buf_o, wr_en_o} !== '0) begin
            errors++; $display("FAIL reset_outputs act_buf_en=%b act_wr=%b exp=all zero", output_buf_en_o, wr_en_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (output_buf_en_o !== 1'b0) begin errors++; $display("FAIL idle_after_reset act=%b exp=0", output_buf_en_o); end
    endtask

    task automatic test_chaining();
        run_layer(3, 3, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_latency_stray();
        run_layer(1, 20, 1'b1, 1'b1, 1'b0, 0);
    endtask

    task automatic test_reset_mid_wait();
        run_layer(20, 20, 1'b0, 1'b0, 1'b0, 3);
        run_layer(2, 2, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_start_edge();
        bit restarted = 1'b0;
        run_layer(2, 2, 1'b0, 1'b0, 1'b1, 0);
        repeat (30) begin
            @(negedge clk);
            if (output_buf_en_o || calc_vld_o) restarted = 1'b1;
        end
        checks++;
        if (restarted) begin errors++; $display("FAIL held_level_restart act=restarted exp=idle"); end
        layer_en = 1'b0;
        repeat (2) @(negedge clk);
        run_layer(5, 1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_chaining();
        test_latency_stray();
        test_reset_mid_wait();
        test_start_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
